// File: rtl/ysyx_23060191_idu_pipe.sv
// Buffered decode stage: a DEPTH-entry {inst,pc} FIFO whose head is decoded combinationally,
// with a RUN/HOLD gate that stalls issue behind serialising instructions until the back end acks.
module ysyx_23060191_idu_pipe #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_inst,
  input  logic [PC_W-1:0]   i_pc,
  input  logic              i_flush,
  input  logic              i_serial_done,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [PC_W-1:0]   o_pc,
  output logic [3:0]        o_cls,
  output logic [2:0]        o_func3,
  output logic [6:0]        o_func7,
  output logic              o_rd_wen,
  output logic [4:0]        o_rd_addr,
  output logic [4:0]        o_rs1_addr,
  output logic [4:0]        o_rs2_addr,
  output logic [XLEN-1:0]   o_imm,
  output logic [11:0]       o_csr_addr,
  output logic              o_illegal
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [3:0] CLS_ALU_R   = 4'd0;
  localparam logic [3:0] CLS_ALU_I   = 4'd1;
  localparam logic [3:0] CLS_LOAD    = 4'd2;
  localparam logic [3:0] CLS_STORE   = 4'd3;
  localparam logic [3:0] CLS_BRANCH  = 4'd4;
  localparam logic [3:0] CLS_JAL     = 4'd5;
  localparam logic [3:0] CLS_JALR    = 4'd6;
  localparam logic [3:0] CLS_LUI     = 4'd7;
  localparam logic [3:0] CLS_AUIPC   = 4'd8;
  localparam logic [3:0] CLS_CSR     = 4'd9;
  localparam logic [3:0] CLS_ECALL   = 4'd10;
  localparam logic [3:0] CLS_MRET    = 4'd11;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  typedef enum logic {ST_RUN, ST_HOLD} state_t;

  function automatic logic [3:0] dec_cls(input logic [31:0] inst);
    logic [3:0] cls;
    cls = CLS_ILLEGAL;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:0])
        7'b0110011: cls = CLS_ALU_R;
        7'b0010011: cls = CLS_ALU_I;
        7'b0000011: cls = CLS_LOAD;
        7'b0100011: cls = CLS_STORE;
        7'b1100011: cls = CLS_BRANCH;
        7'b1101111: cls = CLS_JAL;
        7'b1100111: cls = CLS_JALR;
        7'b0110111: cls = CLS_LUI;
        7'b0010111: cls = CLS_AUIPC;
        7'b1110011: begin
          if (inst[14:12] != 3'b000)     cls = CLS_CSR;
          else if (inst == 32'h00000073) cls = CLS_ECALL;
          else if (inst == 32'h30200073) cls = CLS_MRET;
          else                           cls = CLS_ILLEGAL;
        end
        default:    cls = CLS_ILLEGAL;
      endcase
    end
    return cls;
  endfunction

  // Each immediate is built at its natural signed width, then sign-extended to XLEN.
  function automatic logic signed [XLEN-1:0] dec_imm(input logic [31:0] inst,
                                                     input logic [3:0]  cls);
    logic signed [11:0]     imm_i;
    logic signed [11:0]     imm_s;
    logic signed [12:0]     imm_b;
    logic signed [20:0]     imm_j;
    logic signed [31:0]     imm_u;
    logic signed [XLEN-1:0] imm;
    imm_i = inst[31:20];
    imm_s = {inst[31:25], inst[11:7]};
    imm_b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    imm_u = {inst[31:12], 12'b0};
    case (cls)
      CLS_ALU_I, CLS_LOAD, CLS_JALR: imm = XLEN'(imm_i);
      CLS_STORE:                     imm = XLEN'(imm_s);
      CLS_BRANCH:                    imm = XLEN'(imm_b);
      CLS_JAL:                       imm = XLEN'(imm_j);
      CLS_LUI, CLS_AUIPC:            imm = XLEN'(imm_u);
      default:                       imm = '0;
    endcase
    return imm;
  endfunction

  logic [31:0]     inst_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     count;
  state_t          state;
  state_t          state_nxt;

  logic                   empty;
  logic                   push;
  logic                   pop;
  logic [31:0]            inst_p0;
  logic [PC_W-1:0]        pc_p0;
  logic [3:0]             cls_p0;
  logic                   serial_p0;
  logic                   rd_wen_p0;
  logic [4:0]             rd_p0;
  logic [4:0]             rs1_p0;
  logic [4:0]             rs2_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic [11:0]            csr_p0;
  logic                   vld_p0;

  assign empty   = (count == '0);
  assign o_ready = (count != FULL_CNT);
  assign push    = i_valid && o_ready && !i_flush;
  assign pop     = vld_p0 && i_ready && !i_flush;

  // FIFO storage carries no reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge i_clk) begin
    if (push) begin
      inst_mem[wptr] <= i_inst;
      pc_mem[wptr]   <= i_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (i_flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (pop && serial_p0) state_nxt = ST_HOLD;
      ST_HOLD: if (i_serial_done)    state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
    if (i_flush) state_nxt = ST_RUN;
  end

  // Stage p0: combinational decode of the FIFO head.
  always_comb begin
    inst_p0   = inst_mem[rptr];
    pc_p0     = pc_mem[rptr];
    cls_p0    = dec_cls(inst_p0);
    serial_p0 = cls_p0 inside {CLS_CSR, CLS_ECALL, CLS_MRET, CLS_ILLEGAL};
    rd_wen_p0 = (cls_p0 inside {CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_JAL, CLS_JALR,
                                CLS_LUI, CLS_AUIPC, CLS_CSR}) && (inst_p0[11:7] != 5'd0);
    rd_p0     = rd_wen_p0 ? inst_p0[11:7] : 5'd0;
    rs1_p0    = 5'd0;
    if (cls_p0 inside {CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JALR, CLS_CSR})
      rs1_p0 = inst_p0[19:15];
    else if (cls_p0 == CLS_ECALL)
      rs1_p0 = 5'd15;
    rs2_p0    = (cls_p0 inside {CLS_ALU_R, CLS_STORE, CLS_BRANCH}) ? inst_p0[24:20] : 5'd0;
    imm_p0    = dec_imm(inst_p0, cls_p0);
    csr_p0    = (cls_p0 == CLS_CSR) ? inst_p0[31:20] : 12'd0;
    vld_p0    = (state == ST_RUN) && !empty;
  end

  // Every bundle field is masked by valid so a stalled or empty stage presents all zeros.
  assign o_valid    = vld_p0;
  assign o_pc       = pc_p0 & {PC_W{vld_p0}};
  assign o_cls      = cls_p0 & {4{vld_p0}};
  assign o_func3    = inst_p0[14:12] & {3{vld_p0}};
  assign o_func7    = inst_p0[31:25] & {7{vld_p0}};
  assign o_rd_wen   = rd_wen_p0 & vld_p0;
  assign o_rd_addr  = rd_p0 & {5{vld_p0}};
  assign o_rs1_addr = rs1_p0 & {5{vld_p0}};
  assign o_rs2_addr = rs2_p0 & {5{vld_p0}};
  assign o_imm      = imm_p0 & {XLEN{vld_p0}};
  assign o_csr_addr = csr_p0 & {12{vld_p0}};
  assign o_illegal  = (cls_p0 == CLS_ILLEGAL) & vld_p0;

endmodule

// File: tb/tb_ysyx_23060191_idu_pipe.sv
// Bench for ysyx_23060191_idu_pipe: decode vector table, directed handshake/flush/hold/reset
// sequences, and a random run against a queue-based reference model.
module tb_ysyx_23060191_idu_pipe;
  localparam int XLEN  = 32;
  localparam int PC_W  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [31:0]     i_inst = '0;
  logic [PC_W-1:0] i_pc = '0;
  logic            i_flush = 1'b0;
  logic            i_serial_done = 1'b0;
  logic            o_valid;
  logic            i_ready = 1'b0;
  logic [PC_W-1:0] o_pc;
  logic [3:0]      o_cls;
  logic [2:0]      o_func3;
  logic [6:0]      o_func7;
  logic            o_rd_wen;
  logic [4:0]      o_rd_addr;
  logic [4:0]      o_rs1_addr;
  logic [4:0]      o_rs2_addr;
  logic [XLEN-1:0] o_imm;
  logic [11:0]     o_csr_addr;
  logic            o_illegal;

  always #5 clk = ~clk;

  ysyx_23060191_idu_pipe #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_inst(i_inst), .i_pc(i_pc), .i_flush(i_flush), .i_serial_done(i_serial_done),
    .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_cls(o_cls),
    .o_func3(o_func3), .o_func7(o_func7), .o_rd_wen(o_rd_wen), .o_rd_addr(o_rd_addr),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_imm(o_imm),
    .o_csr_addr(o_csr_addr), .o_illegal(o_illegal)
  );

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        rd_wen;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [11:0] csr;
    logic        illegal;
  } bundle_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  cls;
    logic        rd_wen;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [11:0] csr;
  } vec_t;

  entry_t mq[$];
  bit     hold = 1'b0;
  int     checks = 0;
  int     failures = 0;
  vec_t   vecs[16];

  function automatic logic [3:0] ref_cls(input logic [31:0] inst);
    if (inst[1:0] != 2'b11) return 4'd15;
    case (inst[6:0])
      7'h33: return 4'd0;
      7'h13: return 4'd1;
      7'h03: return 4'd2;
      7'h23: return 4'd3;
      7'h63: return 4'd4;
      7'h6F: return 4'd5;
      7'h67: return 4'd6;
      7'h37: return 4'd7;
      7'h17: return 4'd8;
      7'h73: begin
        if (inst[14:12] != 0)        return 4'd9;
        if (inst == 32'h00000073)    return 4'd10;
        if (inst == 32'h30200073)    return 4'd11;
        return 4'd15;
      end
      default: return 4'd15;
    endcase
  endfunction

  function automatic bit is_serial(input logic [3:0] cls);
    return (cls == 9) || (cls == 10) || (cls == 11) || (cls == 15);
  endfunction

  function automatic bundle_t ref_decode(input entry_t e);
    bundle_t b;
    int      imm;
    logic [3:0] c;
    b = '0;
    c = ref_cls(e.inst);
    b.valid   = 1'b1;
    b.pc      = e.pc;
    b.cls     = c;
    b.func3   = e.inst[14:12];
    b.func7   = e.inst[31:25];
    b.rd_wen  = (c <= 9 && c != 3 && c != 4) && (e.inst[11:7] != 0);
    b.rd      = b.rd_wen ? e.inst[11:7] : 5'd0;
    if (c inside {0, 1, 2, 3, 4, 6, 9}) b.rs1 = e.inst[19:15];
    else if (c == 10)                   b.rs1 = 5'd15;
    if (c inside {0, 3, 4})             b.rs2 = e.inst[24:20];
    case (c)
      1, 2, 6: imm = int'($signed(e.inst[31:20]));
      3:       imm = int'($signed({e.inst[31:25], e.inst[11:7]}));
      4:       imm = int'($signed({e.inst[31], e.inst[7], e.inst[30:25], e.inst[11:8], 1'b0}));
      5:       imm = int'($signed({e.inst[31], e.inst[19:12], e.inst[20], e.inst[30:21], 1'b0}));
      7, 8:    imm = int'(e.inst & 32'hFFFFF000);
      default: imm = 0;
    endcase
    b.imm     = imm;
    b.csr     = (c == 9) ? e.inst[31:20] : 12'd0;
    b.illegal = (c == 15);
    return b;
  endfunction

  function automatic bundle_t model_out();
    bundle_t b;
    b = '0;
    if (!hold && mq.size() > 0) b = ref_decode(mq[0]);
    b.ready = (mq.size() != DEPTH);
    return b;
  endfunction

  function automatic bundle_t dut_out();
    return '{o_valid, o_ready, o_pc, o_cls, o_func3, o_func7, o_rd_wen, o_rd_addr,
             o_rs1_addr, o_rs2_addr, o_imm, o_csr_addr, o_illegal};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_bundle(input string name, input bundle_t exp);
    bundle_t act;
    act = dut_out();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Called at a falling edge: check outputs against the model, drive inputs, advance the model.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic rdy, input logic fl, input logic sd);
    bundle_t cur;
    entry_t  e;
    cur = model_out();
    chk_bundle("model", cur);
    i_valid = v; i_inst = inst; i_pc = pc; i_ready = rdy; i_flush = fl; i_serial_done = sd;
    if (fl) begin
      mq.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        if (sd) hold = 1'b0;
      end else if (cur.valid && rdy) begin
        e = mq.pop_front();
        if (is_serial(ref_cls(e.inst))) hold = 1'b1;
      end
      if (v && cur.ready) mq.push_back('{inst, pc});
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  ops[9];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    r = $urandom;
    case ($urandom_range(0, 11))
      0, 1, 2, 3, 4, 5, 6, 7, 8: return {r[31:7], ops[$urandom_range(0, 8)]};
      9:  return {r[31:15], 3'($urandom_range(1, 7)), r[11:7], 7'h73};
      10: begin
        case ($urandom_range(0, 2))
          0:       return 32'h00000073;
          1:       return 32'h30200073;
          default: return 32'h00100073;
        endcase
      end
      default: return r;
    endcase
  endfunction

  initial begin
    bundle_t e;
    vecs[0]  = '{32'hFFF00293, 4'd1,  1'b1, 5'd5,  5'd0,  5'd0, 32'hFFFFFFFF, 12'h000};
    vecs[1]  = '{32'h002081B3, 4'd0,  1'b1, 5'd3,  5'd1,  5'd2, 32'h00000000, 12'h000};
    vecs[2]  = '{32'hFFC12503, 4'd2,  1'b1, 5'd10, 5'd2,  5'd0, 32'hFFFFFFFC, 12'h000};
    vecs[3]  = '{32'h00512423, 4'd3,  1'b0, 5'd0,  5'd2,  5'd5, 32'h00000008, 12'h000};
    vecs[4]  = '{32'hFE208CE3, 4'd4,  1'b0, 5'd0,  5'd1,  5'd2, 32'hFFFFFFF8, 12'h000};
    vecs[5]  = '{32'h001000EF, 4'd5,  1'b1, 5'd1,  5'd0,  5'd0, 32'h00000800, 12'h000};
    vecs[6]  = '{32'h00008067, 4'd6,  1'b0, 5'd0,  5'd1,  5'd0, 32'h00000000, 12'h000};
    vecs[7]  = '{32'h800003B7, 4'd7,  1'b1, 5'd7,  5'd0,  5'd0, 32'h80000000, 12'h000};
    vecs[8]  = '{32'h12345317, 4'd8,  1'b1, 5'd6,  5'd0,  5'd0, 32'h12345000, 12'h000};
    vecs[9]  = '{32'h300110F3, 4'd9,  1'b1, 5'd1,  5'd2,  5'd0, 32'h00000000, 12'h300};
    vecs[10] = '{32'h00000073, 4'd10, 1'b0, 5'd0,  5'd15, 5'd0, 32'h00000000, 12'h000};
    vecs[11] = '{32'h30200073, 4'd11, 1'b0, 5'd0,  5'd0,  5'd0, 32'h00000000, 12'h000};
    vecs[12] = '{32'h00000000, 4'd15, 1'b0, 5'd0,  5'd0,  5'd0, 32'h00000000, 12'h000};
    vecs[13] = '{32'h00100013, 4'd1,  1'b0, 5'd0,  5'd0,  5'd0, 32'h00000001, 12'h000};
    vecs[14] = '{32'h00100073, 4'd15, 1'b0, 5'd0,  5'd0,  5'd0, 32'h00000000, 12'h000};
    vecs[15] = '{32'h00004501, 4'd15, 1'b0, 5'd0,  5'd0,  5'd0, 32'h00000000, 12'h000};

    // Reset state
    @(negedge clk);
    chk_bundle("reset_bundle", '{valid: 1'b0, ready: 1'b1, default: '0});
    rst_n = 1'b1;
    @(negedge clk);

    // addi x5,x0,-1
    step(1'b1, 32'hFFF00293, 32'h80000000, 1'b0, 1'b0, 1'b0);
    chk("addi_valid", 64'(o_valid), 64'd1);
    chk("addi_cls", 64'(o_cls), 64'd1);
    chk("addi_rd", 64'({o_rd_wen, o_rd_addr}), 64'({1'b1, 5'd5}));
    chk("addi_imm", 64'(o_imm), 64'hFFFFFFFF);
    chk("addi_pc", 64'(o_pc), 64'h80000000);
    idle(1'b1);
    idle(1'b1);

    // Decode table
    for (int i = 0; i < 16; i++) begin
      step(1'b1, vecs[i].inst, 32'h1000 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      e = '0;
      e.valid = 1'b1; e.ready = 1'b1; e.pc = 32'h1000 + 32'(4 * i);
      e.cls = vecs[i].cls; e.func3 = vecs[i].inst[14:12]; e.func7 = vecs[i].inst[31:25];
      e.rd_wen = vecs[i].rd_wen; e.rd = vecs[i].rd; e.rs1 = vecs[i].rs1; e.rs2 = vecs[i].rs2;
      e.imm = vecs[i].imm; e.csr = vecs[i].csr; e.illegal = (vecs[i].cls == 4'd15);
      chk_bundle($sformatf("tbl%0d", i), e);
      idle(1'b1);
      if (vecs[i].cls >= 4'd9) begin
        chk($sformatf("tbl%0d_hold", i), 64'(o_valid), 64'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      end
      idle(1'b0);
    end

    // Backpressure: five offered, four accepted, drained in order
    for (int k = 0; k < 5; k++)
      step(1'b1, 32'h00000093 | (32'(k) << 20), 32'h100 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
    chk("bp_full_ready", 64'(o_ready), 64'd0);
    step(1'b1, 32'h00500093, 32'h110, 1'b0, 1'b0, 1'b0);
    chk("bp_still_full", 64'(o_ready), 64'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_order%0d", k), 64'(o_pc), 64'h100 + 64'(4 * k));
      idle(1'b1);
    end
    chk("bp_drained", 64'(o_valid), 64'd0);

    // ecall holds issue until serial_done
    step(1'b1, 32'h00000073, 32'h200, 1'b1, 1'b0, 1'b0);
    chk("ecall_cls", 64'(o_cls), 64'd10);
    chk("ecall_rs1", 64'(o_rs1_addr), 64'd15);
    step(1'b1, 32'h00100093, 32'h204, 1'b1, 1'b0, 1'b0);
    chk("ecall_hold0", 64'(o_valid), 64'd0);
    idle(1'b1);
    chk("ecall_hold1", 64'(o_valid), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("ecall_resume", 64'({o_valid, o_pc}), {31'd0, 1'b1, 32'h204});
    idle(1'b1);

    // Illegal enters HOLD; addi x0 queued during HOLD issues with rd_wen=0
    step(1'b1, 32'h00000000, 32'h280, 1'b1, 1'b0, 1'b0);
    chk("ill_flag", 64'({o_illegal, o_cls}), {59'd0, 1'b1, 4'd15});
    step(1'b1, 32'h00100013, 32'h284, 1'b1, 1'b0, 1'b0);
    chk("ill_hold", 64'({o_valid, o_ready}), 64'b01);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("ill_addi_x0", 64'({o_valid, o_cls, o_rd_wen, o_rd_addr}), 64'({1'b1, 4'd1, 1'b0, 5'd0}));
    idle(1'b1);

    // Flush with a same-cycle push and two queued
    step(1'b1, 32'h00100093, 32'h300, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 32'h304, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00300093, 32'h308, 1'b0, 1'b1, 1'b0);
    chk("flush_empty", 64'({o_valid, o_ready}), 64'b01);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      chk($sformatf("flush_gone%0d", k), 64'(o_valid), 64'd0);
    end

    // Flush beats serial_done while in HOLD
    step(1'b1, 32'h00000073, 32'h400, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h00100093, 32'h404, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("flush_hold_empty", 64'(o_valid), 64'd0);
    step(1'b1, 32'h00700093, 32'h408, 1'b0, 1'b0, 1'b0);
    chk("flush_hold_run", 64'({o_valid, o_pc}), {31'd0, 1'b1, 32'h408});
    idle(1'b1);

    // Asynchronous reset with three queued entries
    for (int k = 0; k < 3; k++)
      step(1'b1, 32'h00100093, 32'h500 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 64'({o_valid, o_ready}), 64'b01);
    mq.delete();
    hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      chk($sformatf("rst_nostale%0d", k), 64'(o_valid), 64'd0);
    end

    // Random traffic against the model
    for (int n = 0; n < 3000; n++)
      step(($urandom_range(0, 3) != 0), rand_inst(), $urandom & 32'hFFFFFFFC,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 5) == 0));
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
